// File: rtl/temporal_ngram_encoder_pkg.sv
// Shared definitions for the temporal N-gram encoder: default dimensions,
// warm-up/stream phase encoding and the counter-width helper.
package temporal_ngram_encoder_pkg;

  localparam int HV_DIMENSION_DEF = 2000;
  localparam int NGRAM_SIZE_DEF   = 3;

  typedef enum logic {
    NG_WARMUP = 1'b0,
    NG_STREAM = 1'b1
  } ng_phase_e;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/temporal_ngram_encoder_history.sv
// N-1 deep history of accepted hypervectors plus the age-rotated XOR
// reduction that forms the N-gram combinationally from the current input.
module ngram_history_buffer
  import temporal_ngram_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = HV_DIMENSION_DEF,
  parameter int NGRAM_SIZE   = NGRAM_SIZE_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    shift_i,
  input  logic [0:HV_DIMENSION-1] hv_i,
  output logic [0:HV_DIMENSION-1] ngram_o
);

  function automatic logic [0:HV_DIMENSION-1] rotate(input logic [0:HV_DIMENSION-1] v,
                                                     input int k);
    logic [0:HV_DIMENSION-1] r;
    r = '0;
    for (int i = 0; i < HV_DIMENSION; i++) r[(i + k) % HV_DIMENSION] = v[i];
    return r;
  endfunction

  if (NGRAM_SIZE > 1) begin : g_hist
    localparam int DEPTH = NGRAM_SIZE - 1;
    logic [0:HV_DIMENSION-1] hist_q [DEPTH];
    logic [0:HV_DIMENSION-1] hist_d [DEPTH];
    logic [0:HV_DIMENSION-1] ngram;

    always_comb begin
      for (int i = 0; i < DEPTH; i++) hist_d[i] = hist_q[i];
      if (clear_i) begin
        for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
      end else if (shift_i) begin
        hist_d[0] = hv_i;
        for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) hist_q[i] <= hist_d[i];
      end
    end

    // Entry i is i+1 samples old, so it is rotated i+1 positions.
    always_comb begin
      ngram = hv_i;
      for (int i = 0; i < DEPTH; i++) ngram = ngram ^ rotate(hist_q[i], i + 1);
    end

    assign ngram_o = ngram;
  end else begin : g_pass
    assign ngram_o = hv_i;
  end

endmodule

// File: rtl/temporal_ngram_encoder.sv
// Temporal N-gram encoder top: fill counter, registered output stage and the
// valid/ready handshake around the history buffer.
module temporal_ngram_encoder
  import temporal_ngram_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = HV_DIMENSION_DEF,
  parameter int NGRAM_SIZE   = NGRAM_SIZE_DEF
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RBI,
  input  logic                    Clear_SI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] NGramOut_DO,
  output logic                    Warm_SO
);

  localparam int              CNT_W    = ceil_log2(NGRAM_SIZE) + 1;
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(NGRAM_SIZE - 1);

  logic [CNT_W-1:0]        fill_q, fill_d;
  logic                    valid_q, valid_d;
  logic [0:HV_DIMENSION-1] ngram_q, ngram_d;
  logic [0:HV_DIMENSION-1] gram;
  ng_phase_e               phase;
  logic                    accept;

  // The phase is implied by the counter; with N = 1 it is permanently STREAM.
  assign phase       = (fill_q == FILL_MAX) ? NG_STREAM : NG_WARMUP;
  assign ReadyOut_SO = !Clear_SI && (!valid_q || ReadyIn_SI);
  assign accept      = ValidIn_SI && ReadyOut_SO;

  ngram_history_buffer #(
    .HV_DIMENSION(HV_DIMENSION),
    .NGRAM_SIZE  (NGRAM_SIZE)
  ) u_history (
    .clk_i  (Clk_CI),
    .rst_ni (Reset_RBI),
    .clear_i(Clear_SI),
    .shift_i(accept),
    .hv_i   (HypervectorIn_DI),
    .ngram_o(gram)
  );

  always_comb begin
    fill_d  = fill_q;
    valid_d = valid_q;
    ngram_d = ngram_q;
    if (Clear_SI) begin
      fill_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (accept && phase == NG_WARMUP) fill_d = fill_q + CNT_W'(1);
      if (accept && phase == NG_STREAM) begin
        valid_d = 1'b1;
        ngram_d = gram;
      end else if (valid_q && ReadyIn_SI) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      fill_q  <= '0;
      valid_q <= 1'b0;
      ngram_q <= '0;
    end else begin
      fill_q  <= fill_d;
      valid_q <= valid_d;
      ngram_q <= ngram_d;
    end
  end

  assign ValidOut_SO = valid_q;
  assign NGramOut_DO = ngram_q;
  assign Warm_SO     = (phase == NG_STREAM);

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Directed bench for the temporal N-gram encoder: an N=3 instance and an N=1
// instance, with hand-derived expected hypervectors.
module tb_temporal_ngram_encoder;

  localparam int D = 2000;

  logic           clk, rst_n;
  logic           clr3, vin3, rdy3, rin3, vout3, warm3;
  logic [0:D-1]   hv3, ng3;
  logic           clr1, vin1, rdy1, rin1, vout1, warm1;
  logic [0:D-1]   hv1, ng1;

  int checks = 0;
  int errors = 0;

  temporal_ngram_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(3)) u_dut3 (
    .Clk_CI(clk), .Reset_RBI(rst_n), .Clear_SI(clr3), .ValidIn_SI(vin3),
    .ReadyOut_SO(rdy3), .HypervectorIn_DI(hv3), .ValidOut_SO(vout3),
    .ReadyIn_SI(rin3), .NGramOut_DO(ng3), .Warm_SO(warm3)
  );

  temporal_ngram_encoder #(.HV_DIMENSION(D), .NGRAM_SIZE(1)) u_dut1 (
    .Clk_CI(clk), .Reset_RBI(rst_n), .Clear_SI(clr1), .ValidIn_SI(vin1),
    .ReadyOut_SO(rdy1), .HypervectorIn_DI(hv1), .ValidOut_SO(vout1),
    .ReadyIn_SI(rin1), .NGramOut_DO(ng1), .Warm_SO(warm1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bits listed as -1 are unused; expected vectors are built from hand-computed bit sets.
  function automatic logic [0:D-1] bits(input int a, input int b = -1, input int c = -1);
    logic [0:D-1] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  function automatic int first_diff(input logic [0:D-1] a, input logic [0:D-1] b);
    for (int i = 0; i < D; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  // Observed value is the first differing bit index; -1 means identical.
  task automatic chk_hv(input string tag, input logic [0:D-1] obs, input logic [0:D-1] exp);
    chk(tag, first_diff(obs, exp), -1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    clr3 = 1'b0; vin3 = 1'b0; rin3 = 1'b0; hv3 = '0;
    clr1 = 1'b0; vin1 = 1'b0; rin1 = 1'b1; hv1 = '0;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_valid3", int'(vout3), 0);
    chk("rst_warm3", int'(warm3), 0);
    chk("rst_ready3", int'(rdy3), 1);
    chk_hv("rst_data3", ng3, '0);
    chk("rst_warm1", int'(warm1), 1);
    chk("rst_valid1", int'(vout1), 0);
    rst_n = 1'b1;

    // Basic window with e0, N=1 pass-through in parallel
    vin3 = 1'b1; rin3 = 1'b1; hv3 = bits(0);
    vin1 = 1'b1; hv1 = bits(3);
    tick();
    chk("win1_valid", int'(vout3), 0);
    chk("win1_warm", int'(warm3), 0);
    chk("n1_a_valid", int'(vout1), 1);
    chk_hv("n1_a_data", ng1, bits(3));
    hv1 = bits(100);
    tick();
    chk("win2_valid", int'(vout3), 0);
    chk("win2_warm", int'(warm3), 1);
    chk_hv("n1_b_data", ng1, bits(100));
    chk("n1_b_warm", int'(warm1), 1);
    vin1 = 1'b0;
    tick();
    chk("win3_valid", int'(vout3), 1);
    chk_hv("win3_data", ng3, bits(0, 1, 2));
    chk("n1_drain", int'(vout1), 0);

    // Wrap-around through index D-1
    hv3 = bits(1999);
    tick();
    chk_hv("wrap1", ng3, bits(1999, 1, 2));
    tick();
    chk_hv("wrap2", ng3, bits(1999, 0, 2));
    chk("wrap2_valid", int'(vout3), 1);
    tick();
    chk_hv("wrap3", ng3, bits(1999, 0, 1));
    hv3 = bits(0);
    tick();
    chk_hv("wrap4", ng3, bits(1));
    chk("wrap4_valid", int'(vout3), 1);

    // Backpressure: output pending, downstream stalled
    rin3 = 1'b0; hv3 = bits(5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", int'(rdy3), 0);
      chk("bp_valid", int'(vout3), 1);
      chk_hv("bp_data", ng3, bits(1));
    end
    rin3 = 1'b1;
    #1 chk("bp_release_ready", int'(rdy3), 1);
    tick();
    chk("bp_new_valid", int'(vout3), 1);
    chk_hv("bp_new_data", ng3, bits(5));

    // Clear mid-stream with an input presented
    clr3 = 1'b1; hv3 = bits(7);
    #1 chk("clr_ready", int'(rdy3), 0);
    tick();
    chk("clr_valid", int'(vout3), 0);
    chk("clr_warm", int'(warm3), 0);
    chk_hv("clr_data_kept", ng3, bits(5));
    clr3 = 1'b0; hv3 = bits(10);
    tick();
    chk("clr_w1_valid", int'(vout3), 0);
    chk("clr_w1_warm", int'(warm3), 0);
    hv3 = bits(20);
    tick();
    chk("clr_w2_valid", int'(vout3), 0);
    chk("clr_w2_warm", int'(warm3), 1);
    hv3 = bits(30);
    tick();
    chk("clr_w3_valid", int'(vout3), 1);
    chk_hv("clr_w3_data", ng3, bits(30, 21, 12));
    vin3 = 1'b0;
    tick();
    chk("drain_valid", int'(vout3), 0);

    // Async reset while output is valid
    vin3 = 1'b1; hv3 = bits(40);
    tick();
    chk("pre_rst_valid", int'(vout3), 1);
    chk_hv("pre_rst_data", ng3, bits(40, 31, 22));
    vin3 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(vout3), 0);
    chk("arst_warm", int'(warm3), 0);
    chk_hv("arst_data", ng3, '0);
    chk("arst_ready", int'(rdy3), 1);
    chk("arst_warm1", int'(warm1), 1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
